// File: rtl/bg_object_mux_if.sv
// ---------------------------------------------------------------------------
// bg_object_mux_if
// Pixel-stream bundle between the draw stages and the object mux.
//   startOfFrame    : one-cycle pulse on the first pixel of a frame
//   BG_RGB          : background colour (RRRGGGBB)
//   boardersDrawReq : background stage is drawing the border
//   isred           : current background pixel is the red area
//   playerDrawReq / playerRGB : player object request and colour
//   enemyDrawReq  / enemyRGB  : enemy object request and colour
//   RGBOut          : registered final pixel colour towards the VGA controller
// Handshake: none -- every signal is a per-pixel sample taken on each rising
// clock edge; there is no valid/ready, the stream never stalls.
// master = pixel source side, slave = mux side.
// ---------------------------------------------------------------------------
interface bg_object_mux_if;
    logic       startOfFrame;
    logic [7:0] BG_RGB;
    logic       boardersDrawReq;
    logic       isred;
    logic       playerDrawReq;
    logic [7:0] playerRGB;
    logic       enemyDrawReq;
    logic [7:0] enemyRGB;
    logic [7:0] RGBOut;

    modport master (
        output startOfFrame, BG_RGB, boardersDrawReq, isred,
               playerDrawReq, playerRGB, enemyDrawReq, enemyRGB,
        input  RGBOut
    );

    modport slave (
        input  startOfFrame, BG_RGB, boardersDrawReq, isred,
               playerDrawReq, playerRGB, enemyDrawReq, enemyRGB,
        output RGBOut
    );
endinterface

// File: rtl/bg_object_mux.sv
// ---------------------------------------------------------------------------
// bg_object_mux
// Layers player and enemy sprites over the background and detects frames in
// which the player overlapped the red area for enough pixels.
//   clk        : system clock, all state on the rising edge
//   reset      : asynchronous active-high reset
//   pix        : pixel-stream bundle (slave side), carries RGBOut back out
//   clearCount : synchronous clear of hitCount (wins over an increment)
//   redHit     : one-cycle pulse after a frame that declared a hit
//   hitCount   : saturating count of declared hits
//   inCooldown : high while the FSM is in COOLDOWN
//   state_dbg  : raw FSM state (0 = ACTIVE, 1 = COOLDOWN)
// ---------------------------------------------------------------------------
module bg_object_mux #(
    parameter logic [7:0] TRANSPARENT     = 8'hFF,
    parameter int         HIT_MIN_PIXELS  = 4,
    parameter int         COOLDOWN_FRAMES = 2
) (
    input  logic              clk,
    input  logic              reset,
    bg_object_mux_if.slave    pix,
    input  logic              clearCount,
    output logic              redHit,
    output logic [7:0]        hitCount,
    output logic              inCooldown,
    output logic              state_dbg
);
    localparam int              FW      = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [FW-1:0]   CD_INIT = FW'(COOLDOWN_FRAMES);
    localparam logic [11:0]     HIT_CNT = 12'(HIT_MIN_PIXELS);

    typedef enum logic {
        ACTIVE   = 1'b0,
        COOLDOWN = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [FW-1:0] frame_cnt, frame_next;
    logic [11:0]   overlap_cnt;
    logic          hit;

    logic player_drawing, enemy_drawing, overlap;
    logic [7:0] bg_colour;

    assign player_drawing = pix.playerDrawReq && (pix.playerRGB != TRANSPARENT);
    assign enemy_drawing  = pix.enemyDrawReq  && (pix.enemyRGB  != TRANSPARENT);
    assign overlap        = player_drawing && pix.isred;

    // Border and normal background both come from the background stage.
    assign bg_colour = pix.boardersDrawReq ? pix.BG_RGB : pix.BG_RGB;

    assign inCooldown = (state == COOLDOWN);
    assign state_dbg  = state;

    // Frame evaluation happens on startOfFrame using the count gathered
    // before this cycle. The !redHit term keeps the pulse from repeating on
    // back-to-back frame starts when the cooldown is zero frames long.
    always_comb begin
        state_next = state;
        frame_next = frame_cnt;
        hit        = 1'b0;
        if (pix.startOfFrame) begin
            case (state)
                ACTIVE: begin
                    if (overlap_cnt >= HIT_CNT && !redHit) begin
                        hit = 1'b1;
                        if (COOLDOWN_FRAMES != 0) begin
                            state_next = COOLDOWN;
                            frame_next = CD_INIT;
                        end
                    end
                end
                COOLDOWN: begin
                    // Results of frames seen here are dropped.
                    if (frame_cnt <= 1) begin
                        state_next = ACTIVE;
                        frame_next = '0;
                    end else begin
                        frame_next = frame_cnt - 1'b1;
                    end
                end
                default: state_next = ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ACTIVE;
            frame_cnt   <= '0;
            overlap_cnt <= '0;
            redHit      <= 1'b0;
            hitCount    <= 8'h00;
            pix.RGBOut  <= 8'h00;
        end else begin
            state     <= state_next;
            frame_cnt <= frame_next;
            redHit    <= hit;

            if (player_drawing)     pix.RGBOut <= pix.playerRGB;
            else if (enemy_drawing) pix.RGBOut <= pix.enemyRGB;
            else                    pix.RGBOut <= bg_colour;

            // New frame restarts the count, including this cycle's own pixel.
            if (pix.startOfFrame)
                overlap_cnt <= {11'd0, overlap};
            else if (overlap && overlap_cnt != 12'hFFF)
                overlap_cnt <= overlap_cnt + 12'd1;

            if (clearCount)
                hitCount <= 8'h00;
            else if (hit && hitCount != 8'hFF)
                hitCount <= hitCount + 8'd1;
        end
    end
endmodule

// File: tb/tb_bg_object_mux.sv
module tb_bg_object_mux;
    logic       clk = 1'b0;
    logic       reset;
    logic       clearCount;
    logic       redHit, inCooldown, state_dbg;
    logic [7:0] hitCount;
    logic       redHit0, inCooldown0, state_dbg0;
    logic [7:0] hitCount0;

    int checks = 0;
    int errors = 0;

    bg_object_mux_if bus ();
    bg_object_mux_if bus0 ();

    assign bus0.startOfFrame    = bus.startOfFrame;
    assign bus0.BG_RGB          = bus.BG_RGB;
    assign bus0.boardersDrawReq = bus.boardersDrawReq;
    assign bus0.isred           = bus.isred;
    assign bus0.playerDrawReq   = bus.playerDrawReq;
    assign bus0.playerRGB       = bus.playerRGB;
    assign bus0.enemyDrawReq    = bus.enemyDrawReq;
    assign bus0.enemyRGB        = bus.enemyRGB;

    bg_object_mux dut (
        .clk(clk), .reset(reset), .pix(bus), .clearCount(clearCount),
        .redHit(redHit), .hitCount(hitCount), .inCooldown(inCooldown),
        .state_dbg(state_dbg)
    );

    bg_object_mux #(.COOLDOWN_FRAMES(0)) dut0 (
        .clk(clk), .reset(reset), .pix(bus0), .clearCount(clearCount),
        .redHit(redHit0), .hitCount(hitCount0), .inCooldown(inCooldown0),
        .state_dbg(state_dbg0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bg;
        logic       bdr;
        logic       preq;
        logic [7:0] prgb;
        logic       ereq;
        logic [7:0] ergb;
        logic [7:0] exp_rgb;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.startOfFrame    = 1'b0;
        bus.BG_RGB          = 8'h00;
        bus.boardersDrawReq = 1'b0;
        bus.isred           = 1'b0;
        bus.playerDrawReq   = 1'b0;
        bus.playerRGB       = 8'h00;
        bus.enemyDrawReq    = 1'b0;
        bus.enemyRGB        = 8'h00;
    endtask

    task automatic overlap(input int n);
        bus.playerDrawReq = 1'b1;
        bus.playerRGB     = 8'h03;
        bus.isred         = 1'b1;
        repeat (n) tick();
        bus.playerDrawReq = 1'b0;
        bus.isred         = 1'b0;
    endtask

    task automatic sof();
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
    endtask

    task automatic do_hit();
        overlap(4);
        sof();
        sof();
        sof();
    endtask

    initial begin
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 8'h03, 1'b1, 8'hE0, 8'h03};
        vecs[1] = '{8'h1C, 1'b0, 1'b1, 8'hFF, 1'b1, 8'hE0, 8'hE0};
        vecs[2] = '{8'h1C, 1'b0, 1'b0, 8'h03, 1'b1, 8'h1F, 8'h1F};
        vecs[3] = '{8'h1C, 1'b0, 1'b1, 8'hFF, 1'b1, 8'hFF, 8'h1C};
        vecs[4] = '{8'h55, 1'b1, 1'b0, 8'h03, 1'b0, 8'hE0, 8'h55};
        vecs[5] = '{8'hAA, 1'b0, 1'b1, 8'h00, 1'b0, 8'hE0, 8'h00};
        vecs[6] = '{8'hAA, 1'b0, 1'b0, 8'h03, 1'b1, 8'hFF, 8'hAA};

        // Clock/reset
        reset = 1'b1;
        clearCount = 1'b0;
        idle();
        repeat (2) tick();
        check("rst_rgb", bus.RGBOut, 8'h00);
        check("rst_redhit", redHit, 1'b0);
        check("rst_hitcount", hitCount, 8'h00);
        check("rst_incooldown", inCooldown, 1'b0);
        reset = 1'b0;
        tick();

        // RGBOut must not follow inputs before a clock edge
        bus.playerDrawReq = 1'b1;
        bus.playerRGB = 8'h03;
        #1;
        check("rgb_latency", bus.RGBOut, 8'h00);

        // Colour priority table
        for (int i = 0; i < 7; i++) begin
            bus.BG_RGB          = vecs[i].bg;
            bus.boardersDrawReq = vecs[i].bdr;
            bus.playerDrawReq   = vecs[i].preq;
            bus.playerRGB       = vecs[i].prgb;
            bus.enemyDrawReq    = vecs[i].ereq;
            bus.enemyRGB        = vecs[i].ergb;
            tick();
            check($sformatf("rgb_vec%0d", i), bus.RGBOut, vecs[i].exp_rgb);
        end
        idle();

        // First qualifying frame (pixels before the first startOfFrame count)
        overlap(4);
        sof();
        check("f1_redhit", redHit, 1'b1);
        check("f1_hitcount", hitCount, 8'd1);
        check("f1_incooldown", inCooldown, 1'b1);
        check("f1_cd0_hitcount", hitCount0, 8'd1);
        check("f1_cd0_incooldown", inCooldown0, 1'b0);
        tick();
        check("f1_redhit_single", redHit, 1'b0);

        // Cooldown frames discard qualifying results
        overlap(4);
        sof();
        check("f2_redhit", redHit, 1'b0);
        check("f2_hitcount", hitCount, 8'd1);
        check("f2_incooldown", inCooldown, 1'b1);
        check("f2_cd0_redhit", redHit0, 1'b1);
        check("f2_cd0_hitcount", hitCount0, 8'd2);
        overlap(4);
        sof();
        check("f3_redhit", redHit, 1'b0);
        check("f3_hitcount", hitCount, 8'd1);
        check("f3_incooldown", inCooldown, 1'b0);
        overlap(4);
        sof();
        check("f4_redhit", redHit, 1'b1);
        check("f4_hitcount", hitCount, 8'd2);
        sof();
        sof();
        check("f4_cd_done", inCooldown, 1'b0);

        // 3 overlap pixels; the startOfFrame cycle itself is an overlap pixel
        overlap(3);
        bus.playerDrawReq = 1'b1;
        bus.playerRGB = 8'h03;
        bus.isred = 1'b1;
        bus.startOfFrame = 1'b1;
        tick();
        idle();
        check("three_redhit", redHit, 1'b0);
        check("three_hitcount", hitCount, 8'd2);
        // 1 carried + 3 more reaches the threshold
        overlap(3);
        sof();
        check("carry_redhit", redHit, 1'b1);
        check("carry_hitcount", hitCount, 8'd3);
        sof();
        sof();

        // Pixels that are not overlaps: transparent player, non-red, enemy on red
        bus.playerDrawReq = 1'b1; bus.playerRGB = 8'hFF; bus.isred = 1'b1;
        repeat (4) tick();
        bus.playerRGB = 8'h03; bus.isred = 1'b0;
        repeat (4) tick();
        bus.playerDrawReq = 1'b0; bus.enemyDrawReq = 1'b1; bus.enemyRGB = 8'h03; bus.isred = 1'b1;
        repeat (4) tick();
        idle();
        overlap(3);
        sof();
        check("nonoverlap_redhit", redHit, 1'b0);
        check("nonoverlap_hitcount", hitCount, 8'd3);

        // overlap counter saturates rather than wrapping to a small value
        overlap(4098);
        sof();
        check("ovsat_redhit", redHit, 1'b1);
        check("ovsat_hitcount", hitCount, 8'd4);
        sof();
        sof();

        // clearCount, saturation at 255, clear wins over increment
        clearCount = 1'b1;
        tick();
        clearCount = 1'b0;
        check("clear_hitcount", hitCount, 8'd0);
        repeat (255) do_hit();
        check("sat_preload", hitCount, 8'd255);
        overlap(4);
        sof();
        check("sat_redhit", redHit, 1'b1);
        check("sat_hitcount", hitCount, 8'd255);
        sof();
        sof();
        overlap(4);
        clearCount = 1'b1;
        sof();
        clearCount = 1'b0;
        check("clrwin_redhit", redHit, 1'b1);
        check("clrwin_hitcount", hitCount, 8'd0);
        sof();
        sof();

        // Mid-frame asynchronous reset
        overlap(4);
        sof();
        check("prerst_hitcount", hitCount, 8'd1);
        check("prerst_incooldown", inCooldown, 1'b1);
        bus.playerDrawReq = 1'b1; bus.playerRGB = 8'h03; bus.isred = 1'b1;
        repeat (3) tick();
        check("prerst_rgb", bus.RGBOut, 8'h03);
        #2;
        reset = 1'b1;
        #1;
        check("arst_rgb", bus.RGBOut, 8'h00);
        check("arst_redhit", redHit, 1'b0);
        check("arst_hitcount", hitCount, 8'd0);
        check("arst_incooldown", inCooldown, 1'b0);
        check("arst_cd0_hitcount", hitCount0, 8'd0);
        repeat (2) tick();
        check("rsthold_rgb", bus.RGBOut, 8'h00);
        reset = 1'b0;
        overlap(2);
        sof();
        check("postrst_redhit", redHit, 1'b0);
        check("postrst_hitcount", hitCount, 8'd0);
        check("postrst_incooldown", inCooldown, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
